register_file: RTL and testbench

Storage array for the TMP8 datapath: eight 8-bit general-purpose registers built from per-bit synchronous-reset storage cells. It has one write port and two registered read ports. The block is the read side of the register-storage interface: the control unit writes results and the ALU fetches operands through a request/valid handshake. Read data is registered with a fixed 1-cycle latency and includes write-first bypass, so back-to-back dependent instructions see fresh data.

---
 rtl/register_file.sv | 103 ++++++++++
 tb/tb_register_file.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
// register_file : 8 x 8-bit storage array, one write port, two registered
//                 read ports with write-first bypass and a_eq_b flag.
// Revision 1.0
// ============================================================================

module register_file_bit_cell (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic d_i,
  output logic q_o
);

  logic bit_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_q <= 1'b0;
    end else if (en_i) begin
      bit_q <= d_i;
    end
  end

  assign q_o = bit_q;

endmodule

module register_file #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] raddr_a,
  input  logic [ADDR_WIDTH-1:0] raddr_b,
  output logic [DATA_WIDTH-1:0] rdata_a,
  output logic [DATA_WIDTH-1:0] rdata_b,
  output logic                  rd_valid,
  output logic                  a_eq_b
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  wire [DATA_WIDTH-1:0] mem_w [DEPTH];

  genvar r, b;
  generate
    for (r = 0; r < DEPTH; r++) begin : g_row
      logic row_we;
      assign row_we = we && (waddr == ADDR_WIDTH'(r));
      for (b = 0; b < DATA_WIDTH; b++) begin : g_bit
        register_file_bit_cell u_cell (
          .clk   (clk),
          .reset (reset),
          .en_i  (row_we),
          .d_i   (wdata[b]),
          .q_o   (mem_w[r][b])
        );
      end
    end
  endgenerate

  logic [DATA_WIDTH-1:0] rdata_a_q, rdata_a_d;
  logic [DATA_WIDTH-1:0] rdata_b_q, rdata_b_d;
  logic                  rd_valid_q;
  logic                  a_eq_b_q, a_eq_b_d;

  // Write-first: a same-cycle write to the addressed register wins over storage.
  always_comb begin
    rdata_a_d = (we && (waddr == raddr_a)) ? wdata : mem_w[raddr_a];
    rdata_b_d = (we && (waddr == raddr_b)) ? wdata : mem_w[raddr_b];
    a_eq_b_d  = (rdata_a_d == rdata_b_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_a_q  <= '0;
      rdata_b_q  <= '0;
      rd_valid_q <= 1'b0;
      a_eq_b_q   <= 1'b0;
    end else begin
      rd_valid_q <= rd_req;
      if (rd_req) begin
        rdata_a_q <= rdata_a_d;
        rdata_b_q <= rdata_b_d;
        a_eq_b_q  <= a_eq_b_d;
      end
    end
  end

  assign rdata_a  = rdata_a_q;
  assign rdata_b  = rdata_b_q;
  assign rd_valid = rd_valid_q;
  assign a_eq_b   = a_eq_b_q;

endmodule
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ============================================================================
// tb_register_file : random + directed checks against an array-based model.
// Revision 1.0
// ============================================================================
module tb_register_file;

  logic       clk = 1'b0;
  logic       reset, we, rd_req;
  logic [2:0] waddr, raddr_a, raddr_b;
  logic [7:0] wdata;
  logic [7:0] rdata_a, rdata_b;
  logic       rd_valid, a_eq_b;

  int checks   = 0;
  int failures = 0;

  logic [7:0] m_mem [8];
  logic [7:0] e_a, e_b;
  logic       e_v, e_eq;

  register_file dut (
    .clk     (clk),
    .reset   (reset),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .rd_req  (rd_req),
    .raddr_a (raddr_a),
    .raddr_b (raddr_b),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b),
    .rd_valid(rd_valid),
    .a_eq_b  (a_eq_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, apply the architectural rules to the model, compare.
  task automatic cyc(input logic t_rst, input logic t_we, input logic [2:0] t_wa,
                     input logic [7:0] t_wd, input logic t_rd,
                     input logic [2:0] t_ra, input logic [2:0] t_rb);
    reset = t_rst; we = t_we; waddr = t_wa; wdata = t_wd;
    rd_req = t_rd; raddr_a = t_ra; raddr_b = t_rb;
    @(posedge clk);
    if (t_rst) begin
      for (int i = 0; i < 8; i++) m_mem[i] = 8'h00;
      e_a = 8'h00; e_b = 8'h00; e_v = 1'b0; e_eq = 1'b0;
    end else begin
      e_v = t_rd;
      if (t_rd) begin
        e_a  = (t_we && t_wa == t_ra) ? t_wd : m_mem[t_ra];
        e_b  = (t_we && t_wa == t_rb) ? t_wd : m_mem[t_rb];
        e_eq = (e_a == e_b);
      end
      if (t_we) m_mem[t_wa] = t_wd;
    end
    #1;
    chk("rdata_a", rdata_a, e_a);
    chk("rdata_b", rdata_b, e_b);
    chk("rd_valid", {7'd0, rd_valid}, {7'd0, e_v});
    chk("a_eq_b", {7'd0, a_eq_b}, {7'd0, e_eq});
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    cyc(1'b0, 1'b1, a, d, 1'b0, 3'd0, 3'd0);
  endtask

  task automatic rd(input logic [2:0] a, input logic [2:0] b);
    cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, a, b);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0);
  endtask

  initial begin
    logic [7:0] hold_a, hold_b;

    cyc(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0);
    chk("reset_valid", {7'd0, rd_valid}, 8'h00);

    // Randomized traffic; narrow data range makes a_eq_b hits common.
    for (int n = 0; n < 300; n++) begin
      cyc(($urandom_range(0, 24) == 0), $urandom_range(0, 1) == 1,
          3'($urandom_range(0, 7)), 8'($urandom_range(0, 3)),
          $urandom_range(0, 2) != 0,
          3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end

    // Reset clears every register.
    for (int i = 0; i < 8; i++) wr(3'(i), 8'hA5);
    cyc(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0);
    chk("rst_valid_low", {7'd0, rd_valid}, 8'h00);
    for (int i = 0; i < 8; i++) begin
      rd(3'(i), 3'(7 - i));
      chk("rst_clear_a", rdata_a, 8'h00);
      chk("rst_clear_b", rdata_b, 8'h00);
      chk("rst_read_valid", {7'd0, rd_valid}, 8'h01);
    end

    // Basic write then read.
    wr(3'd2, 8'h3C);
    wr(3'd5, 8'hF0);
    rd(3'd2, 3'd5);
    chk("basic_a", rdata_a, 8'h3C);
    chk("basic_b", rdata_b, 8'hF0);
    chk("basic_eq", {7'd0, a_eq_b}, 8'h00);

    // Write-first bypass on both ports.
    wr(3'd4, 8'h11);
    cyc(1'b0, 1'b1, 3'd4, 8'h99, 1'b1, 3'd4, 3'd4);
    chk("bypass_a", rdata_a, 8'h99);
    chk("bypass_b", rdata_b, 8'h99);
    chk("bypass_eq", {7'd0, a_eq_b}, 8'h01);
    rd(3'd4, 3'd2);
    chk("after_bypass", rdata_a, 8'h99);
    cyc(1'b0, 1'b1, 3'd6, 8'h5A, 1'b1, 3'd2, 3'd6);
    chk("bypass_b_only_a", rdata_a, 8'h3C);
    chk("bypass_b_only_b", rdata_b, 8'h5A);

    // Single request then idle: one-cycle valid pulse, data held.
    rd(3'd2, 3'd5);
    hold_a = rdata_a; hold_b = rdata_b;
    chk("pulse_valid", {7'd0, rd_valid}, 8'h01);
    for (int k = 0; k < 3; k++) begin
      idle();
      chk("pulse_idle_valid", {7'd0, rd_valid}, 8'h00);
      chk("pulse_hold_a", rdata_a, 8'h3C);
      chk("pulse_hold_b", rdata_b, 8'hF0);
    end

    // Streaming reads.
    for (int i = 0; i < 8; i++) wr(3'(i), 8'(16 * i));
    for (int i = 0; i < 8; i++) begin
      rd(3'(i), 3'(7 - i));
      chk("stream_a", rdata_a, 8'(16 * i));
      chk("stream_b", rdata_b, 8'(16 * (7 - i)));
      chk("stream_valid", {7'd0, rd_valid}, 8'h01);
      chk("stream_eq", {7'd0, a_eq_b}, 8'h00);
    end

    // Reset wins over same-edge write and read.
    cyc(1'b1, 1'b1, 3'd1, 8'h77, 1'b1, 3'd1, 3'd1);
    chk("rstpri_valid", {7'd0, rd_valid}, 8'h00);
    chk("rstpri_a", rdata_a, 8'h00);
    chk("rstpri_b", rdata_b, 8'h00);
    rd(3'd1, 3'd3);
    chk("rstpri_r1", rdata_a, 8'h00);
    chk("rstpri_valid_after", {7'd0, rd_valid}, 8'h01);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
